version_info_streamer: RTL and testbench

- Emits a fixed 16-byte build-identification record (magic, length, version, BCD build timestamp, trailer) on a valid/ready stream.
- Record width per beat is parametrised.
- Triggered by request pulse or optional periodic auto-trigger.
- Sits between the build-version constants (wired in at top level) and the host link / debug UART packetiser.
- Successor to constant-only version info: adds snapshotting, serialisation, backpressure, repeat and optional integrity byte.

---
 rtl/version_stream_pkg.sv | 43 ++++
 rtl/version_info_streamer_if.sv | 13 +
 rtl/version_info_streamer.sv | 155 +++++++++++++++
 tb/tb_version_info_streamer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/version_stream_pkg.sv
// Shared constants, record layout offsets, FSM states and CRC helper
// for the build-identification record streamer.
package version_stream_pkg;

    localparam int REC_BYTES = 16;
    localparam int REC_BITS  = REC_BYTES * 8;
    localparam logic [7:0] REC_LEN = 8'h10;

    localparam int OFF_MAGIC   = 0;
    localparam int OFF_LEN     = 2;
    localparam int OFF_MAJOR   = 3;
    localparam int OFF_MINOR   = 4;
    localparam int OFF_PATCH   = 5;
    localparam int OFF_BUILD   = 6;
    localparam int OFF_YEAR    = 7;
    localparam int OFF_MONTH   = 9;
    localparam int OFF_DAY     = 10;
    localparam int OFF_HOUR    = 11;
    localparam int OFF_MINUTE  = 12;
    localparam int OFF_SECOND  = 13;
    localparam int OFF_RSVD    = 14;
    localparam int OFF_TRAILER = 15;

    typedef enum logic {IDLE, SEND} state_t;
    typedef logic [REC_BITS-1:0] rec_t;

    // CRC-8, poly 0x07, init 0, no reflection, no xorout.
    // Byte 0 of the record sits in the MSBs; only the first n bytes count.
    function automatic logic [7:0] crc8_07(input rec_t rec, input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < REC_BYTES; i++) begin
            if (i < n) begin
                c = c ^ rec[REC_BITS-1-8*i -: 8];
                for (int b = 0; b < 8; b++) begin
                    c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/version_info_streamer_if.sv
// Valid/ready beat stream carrying the version record.
// master: m_valid/m_data/m_last out, m_ready in; slave mirrors it.
interface version_info_streamer_if #(
    parameter int DATA_W = 8
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/version_info_streamer.sv
// Snapshots build-version inputs into a 16-byte record and streams it
// big-endian over m (valid/ready, m_last on final beat) on req, a pending
// retrigger or a periodic tick. Ports: clk, rst_n (async low), ver_*,
// req, busy, m (master stream). Optional VERSION_STREAM_CRC_EN puts a
// CRC-8 of bytes 0..14 in byte 15; otherwise byte 15 is 8'h00.
module version_info_streamer
    import version_stream_pkg::*;
#(
    parameter int          DATA_W        = 8,
    parameter int          PERIOD_CYCLES = 0,
    parameter logic [15:0] MAGIC         = 16'h5649
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ver_major,
    input  logic [7:0]  ver_minor,
    input  logic [7:0]  ver_patch,
    input  logic [7:0]  ver_build,
    input  logic [15:0] ver_year,
    input  logic [7:0]  ver_month,
    input  logic [7:0]  ver_day,
    input  logic [7:0]  ver_hour,
    input  logic [7:0]  ver_minute,
    input  logic [7:0]  ver_second,
    input  logic        req,
    output logic        busy,
    version_info_streamer_if.master m
);

    localparam int BEATS  = REC_BITS / DATA_W;
    localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BEATS - 1);

    generate
        if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 ||
              DATA_W == 64 || DATA_W == 128)) begin : g_bad_width
            $fatal(1, "version_info_streamer: illegal DATA_W");
        end
    endgenerate

    logic [7:0] w_bytes [REC_BYTES];
    rec_t       w_rec;
    logic       w_tick;
    logic       w_trig;
    logic       w_hs;

    always_comb begin
        w_bytes[OFF_MAGIC]     = MAGIC[15:8];
        w_bytes[OFF_MAGIC+1]   = MAGIC[7:0];
        w_bytes[OFF_LEN]       = REC_LEN;
        w_bytes[OFF_MAJOR]     = ver_major;
        w_bytes[OFF_MINOR]     = ver_minor;
        w_bytes[OFF_PATCH]     = ver_patch;
        w_bytes[OFF_BUILD]     = ver_build;
        w_bytes[OFF_YEAR]      = ver_year[15:8];
        w_bytes[OFF_YEAR+1]    = ver_year[7:0];
        w_bytes[OFF_MONTH]     = ver_month;
        w_bytes[OFF_DAY]       = ver_day;
        w_bytes[OFF_HOUR]      = ver_hour;
        w_bytes[OFF_MINUTE]    = ver_minute;
        w_bytes[OFF_SECOND]    = ver_second;
        w_bytes[OFF_RSVD]      = 8'h00;
        w_bytes[OFF_TRAILER]   = 8'h00;
        w_rec = '0;
        for (int i = 0; i < REC_BYTES; i++) begin
            w_rec[REC_BITS-1-8*i -: 8] = w_bytes[i];
        end
`ifdef VERSION_STREAM_CRC_EN
        w_rec[7:0] = crc8_07(w_rec, OFF_TRAILER);
`endif
    end

    generate
        if (PERIOD_CYCLES > 0) begin : g_period
            localparam int CW = $clog2(PERIOD_CYCLES + 1);
            localparam logic [CW-1:0] CMAX = CW'(PERIOD_CYCLES - 1);
            logic [CW-1:0] r_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (r_cnt == CMAX) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            assign w_tick = (r_cnt == CMAX);
        end else begin : g_no_period
            assign w_tick = 1'b0;
        end
    endgenerate

    state_t            r_state;
    rec_t              r_rec;
    logic [BIDX_W-1:0] r_beat;
    logic              r_pend;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;

    assign w_trig = req | r_pend | w_tick;
    assign w_hs   = r_valid & m.m_ready;

    // r_rec shifts left one beat per handshake, so the current beat
    // is always the top DATA_W bits and stays put while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rec   <= '0;
            r_beat  <= '0;
            r_pend  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        r_rec   <= w_rec;
                        r_pend  <= 1'b0;
                        r_beat  <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_last  <= (BEATS == 1);
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (req | w_tick) begin
                        r_pend <= 1'b1;
                    end
                    if (w_hs) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                            r_rec  <= r_rec << DATA_W;
                            r_last <= ((r_beat + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign m.m_valid = r_valid;
    assign m.m_last  = r_last;
    assign m.m_data  = r_rec[REC_BITS-1 -: DATA_W];

endmodule

// File: tb/tb_version_info_streamer.sv
// Directed bench for version_info_streamer: DATA_W 8/32/128 request-only
// instances plus a DATA_W=32, PERIOD_CYCLES=100 instance.
module tb_version_info_streamer;
    import version_stream_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic rstp_n;
    logic [7:0]  maj, mnr, pat, bld;
    logic [15:0] yr;
    logic [7:0]  mon, day, hr, mnt, sec;
    logic req8, req32, req128, reqp;
    logic busy8, busy32, busy128, busyp;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    version_info_streamer_if #(.DATA_W(8))   if8 ();
    version_info_streamer_if #(.DATA_W(32))  if32 ();
    version_info_streamer_if #(.DATA_W(128)) if128 ();
    version_info_streamer_if #(.DATA_W(32))  ifp ();

    version_info_streamer #(.DATA_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .ver_major(maj), .ver_minor(mnr),
        .ver_patch(pat), .ver_build(bld), .ver_year(yr), .ver_month(mon),
        .ver_day(day), .ver_hour(hr), .ver_minute(mnt), .ver_second(sec),
        .req(req8), .busy(busy8), .m(if8.master)
    );
    version_info_streamer #(.DATA_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .ver_major(maj), .ver_minor(mnr),
        .ver_patch(pat), .ver_build(bld), .ver_year(yr), .ver_month(mon),
        .ver_day(day), .ver_hour(hr), .ver_minute(mnt), .ver_second(sec),
        .req(req32), .busy(busy32), .m(if32.master)
    );
    version_info_streamer #(.DATA_W(128)) u128 (
        .clk(clk), .rst_n(rst_n), .ver_major(maj), .ver_minor(mnr),
        .ver_patch(pat), .ver_build(bld), .ver_year(yr), .ver_month(mon),
        .ver_day(day), .ver_hour(hr), .ver_minute(mnt), .ver_second(sec),
        .req(req128), .busy(busy128), .m(if128.master)
    );
    version_info_streamer #(.DATA_W(32), .PERIOD_CYCLES(100)) up (
        .clk(clk), .rst_n(rstp_n), .ver_major(maj), .ver_minor(mnr),
        .ver_patch(pat), .ver_build(bld), .ver_year(yr), .ver_month(mon),
        .ver_day(day), .ver_hour(hr), .ver_minute(mnt), .ver_second(sec),
        .req(reqp), .busy(busyp), .m(ifp.master)
    );

    logic [7:0] exp_b [16];

    logic [127:0] cap8[$],   cap32[$],   cap128[$],   capp[$];
    bit           lst8[$],   lst32[$],   lst128[$],   lstp[$];
    int           stp8[$],   stpp[$];

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] tb_crc(input logic [7:0] b [16], input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = c ^ b[i];
            for (int k = 0; k < 8; k++) begin
                if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
                else      c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    function automatic logic [127:0] exp_word(input int w, input int k);
        logic [127:0] v;
        v = '0;
        for (int j = 0; j < w / 8; j++) begin
            v = (v << 8) | 128'(exp_b[k * (w / 8) + j]);
        end
        return v;
    endfunction

    function automatic logic [127:0] qget(input logic [127:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    // Handshakes are sampled on the falling edge, half a cycle before
    // the rising edge that completes them.
    logic        stall32_q = 1'b0;
    logic [31:0] prev_d32  = '0;
    logic        prev_l32  = 1'b0;

    always @(negedge clk) begin
        if (if8.m_valid && if8.m_ready) begin
            cap8.push_back(128'(if8.m_data));
            lst8.push_back(if8.m_last);
            stp8.push_back(cyc);
        end
        if (if128.m_valid && if128.m_ready) begin
            cap128.push_back(if128.m_data);
            lst128.push_back(if128.m_last);
        end
        if (ifp.m_valid && ifp.m_ready) begin
            capp.push_back(128'(ifp.m_data));
            lstp.push_back(ifp.m_last);
            stpp.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (stall32_q) begin
            chk("stall_valid32", 128'(if32.m_valid), 128'(1));
            chk("stall_data32", 128'(if32.m_data), 128'(prev_d32));
            chk("stall_last32", 128'(if32.m_last), 128'(prev_l32));
        end
        if (if32.m_valid && if32.m_ready) begin
            cap32.push_back(128'(if32.m_data));
            lst32.push_back(if32.m_last);
        end
        stall32_q <= if32.m_valid && !if32.m_ready;
        prev_d32  <= if32.m_data;
        prev_l32  <= if32.m_last;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int b8, b32, b128, bp, nb, rel, got;
        logic [127:0] s;

        rst_n = 1'b0; rstp_n = 1'b0;
        req8 = 1'b0; req32 = 1'b0; req128 = 1'b0; reqp = 1'b0;
        if8.m_ready = 1'b1; if32.m_ready = 1'b1;
        if128.m_ready = 1'b1; ifp.m_ready = 1'b1;
        maj = 8'h00; mnr = 8'h00; pat = 8'h00; bld = 8'h3A;
        yr = 16'h2025; mon = 8'h11; day = 8'h07;
        hr = 8'h15; mnt = 8'h46; sec = 8'h38;
        exp_b = '{8'h56, 8'h49, 8'h10, 8'h00, 8'h00, 8'h00, 8'h3A, 8'h20,
                  8'h25, 8'h11, 8'h07, 8'h15, 8'h46, 8'h38, 8'h00, 8'h00};
`ifdef VERSION_STREAM_CRC_EN
        s = {"123456789", 56'h0};
        chk("crc_unit", 128'(crc8_07(s, 9)), 128'(8'hF4));
        exp_b[15] = tb_crc(exp_b, 15);
`else
        s = '0;
`endif

        step(3);
        chk("rst_busy8", 128'(busy8), 0);
        chk("rst_valid8", 128'(if8.m_valid), 0);
        chk("rst_data8", 128'(if8.m_data), 0);
        chk("rst_last8", 128'(if8.m_last), 0);
        chk("rst_valid32", 128'(if32.m_valid), 0);
        chk("rst_data128", if128.m_data, 0);
        rst_n = 1'b1;
        step(2);
        chk("idle_valid8", 128'(if8.m_valid), 0);

        // Single request on the 8/32/128-bit instances, sink always ready.
        b8 = cap8.size(); b32 = cap32.size(); b128 = cap128.size();
        req8 = 1'b1; req32 = 1'b1; req128 = 1'b1;
        step(1);
        req8 = 1'b0; req32 = 1'b0; req128 = 1'b0;
        chk("lat_valid8", 128'(if8.m_valid), 1);
        chk("lat_busy8", 128'(busy8), 1);
        nb = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy8) nb++;
        end
        #1;
        chk("busy_cycles8", 128'(nb), 128'(16));
        chk("beats8", 128'(cap8.size() - b8), 128'(16));
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("byte8_%0d", i), qget(cap8, b8 + i), 128'(exp_b[i]));
            chk($sformatf("last8_%0d", i), 128'((b8 + i < lst8.size()) ? lst8[b8 + i] : 1'bx),
                128'(i == 15));
        end
        chk("beats32", 128'(cap32.size() - b32), 128'(4));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("word32_%0d", k), qget(cap32, b32 + k), exp_word(32, k));
            chk($sformatf("last32_%0d", k), 128'((b32 + k < lst32.size()) ? lst32[b32 + k] : 1'bx),
                128'(k == 3));
        end
        chk("beats128", 128'(cap128.size() - b128), 128'(1));
        chk("word128", qget(cap128, b128), exp_word(128, 0));
        chk("last128", 128'((b128 < lst128.size()) ? lst128[b128] : 1'bx), 128'(1));

        // Random sink stalls with ver_build changed mid-record.
        b32 = cap32.size();
        req32 = 1'b1;
        step(1);
        req32 = 1'b0;
        for (int it = 0; it < 200; it++) begin
            if32.m_ready = (it == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            if (it == 3) bld = 8'h77;
            step(1);
            if (cap32.size() - b32 >= 4) break;
        end
        if32.m_ready = 1'b1;
        step(10);
        bld = 8'h3A;
        chk("stall_beats32", 128'(cap32.size() - b32), 128'(4));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall_word32_%0d", k), qget(cap32, b32 + k), exp_word(32, k));
        end

        // Requests while busy merge into one pending retrigger.
        b8 = cap8.size();
        req8 = 1'b1; step(1); req8 = 1'b0;
        step(3);
        req8 = 1'b1; step(1); req8 = 1'b0;
        step(2);
        req8 = 1'b1; step(1); req8 = 1'b0;
        step(60);
        chk("pend_beats8", 128'(cap8.size() - b8), 128'(32));
        chk("pend_gap8",
            128'((b8 + 16 < stp8.size()) ? stp8[b8 + 16] - stp8[b8 + 15] : -1),
            128'(2));
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pend_byte8_%0d", i), qget(cap8, b8 + 16 + i), 128'(exp_b[i]));
        end
        chk("pend_last8", 128'((b8 + 31 < lst8.size()) ? lst8[b8 + 31] : 1'bx), 128'(1));

        // Periodic auto-trigger every 100 cycles.
        bp = capp.size();
        rstp_n = 1'b1;
        rel = cyc;
        step(320);
        chk("per_beats", 128'(capp.size() - bp), 128'(12));
        chk("per_first", 128'((bp < stpp.size()) ? stpp[bp] - rel : -1), 128'(100));
        chk("per_gap1",
            128'((bp + 4 < stpp.size()) ? stpp[bp + 4] - stpp[bp] : -1), 128'(100));
        chk("per_gap2",
            128'((bp + 8 < stpp.size()) ? stpp[bp + 8] - stpp[bp + 4] : -1), 128'(100));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("per_word_%0d", k), qget(capp, bp + k), exp_word(32, k));
        end

        // Reset in the middle of a periodic record.
        got = 0;
        for (int it = 0; it < 200; it++) begin
            if (ifp.m_valid) begin
                got = 1;
                break;
            end
            step(1);
        end
        chk("per_wait_start", 128'(got), 128'(1));
        step(1);
        chk("per_mid_valid", 128'(ifp.m_valid), 1);
        rstp_n = 1'b0;
        #1;
        chk("rst_abort_valid", 128'(ifp.m_valid), 0);
        chk("rst_abort_busy", 128'(busyp), 0);
        bp = capp.size();
        step(3);
        rstp_n = 1'b1;
        rel = cyc;
        step(110);
        chk("post_rst_beats", 128'(capp.size() - bp), 128'(4));
        chk("post_rst_first", 128'((bp < stpp.size()) ? stpp[bp] - rel : -1), 128'(100));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("post_rst_word_%0d", k), qget(capp, bp + k), exp_word(32, k));
            chk($sformatf("post_rst_last_%0d", k),
                128'((bp + k < lstp.size()) ? lstp[bp + k] : 1'bx), 128'(k == 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
